// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, fetch FSM states,
// reset PC default and the fetch buffer entry layout.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetchState_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } bufEntry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction FIFO of {pc, inst} entries with flush, push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [31:0]      pushPc,
    input  logic [31:0]      pushInst,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [31:0]      headPc,
    output logic [31:0]      headInst
);

    bufEntry_t        entries [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; only the pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (push && !flush) entries[wrPtr] <= '{pc: pushPc, inst: pushInst};
    end

    assign headPc   = entries[rdPtr].pc;
    assign headInst = entries[rdPtr].inst;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect handling.
// Optional macro IFU_MISALIGN_CHECK_EN enables misaligned-redirect faulting.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [6:0]  inst_opcode,
    input  logic        inst_ready,
    output logic        misalign_fault
);

    localparam int              CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    fetchState_t      state;
    fetchState_t      stateNext;
    logic [31:0]      fetchPc;
    logic [31:0]      reqPc;
    logic [CNT_W-1:0] count;
    logic             transfer;
    logic             push;
    logic             pop;
    logic             fault;

    `ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                fault <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) fault <= 1'b1;
    end
    `else
    assign fault = 1'b0;
    `endif

    // Buffer space for the in-flight response is reserved by only issuing below capacity.
    assign imem_req_valid = (state == FETCH) && !reset && !fault && (count < DEPTH_CNT);
    assign imem_req_addr  = fetchPc;
    assign transfer       = imem_req_valid && imem_req_ready;
    assign pop            = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        stateNext = state;
        push      = 1'b0;
        unique case (state)
            FETCH: if (transfer) stateNext = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    push      = 1'b1;
                    stateNext = FETCH;
                end
            end
            DROP:    if (imem_rsp_valid) stateNext = FETCH;
            default: stateNext = FETCH;
        endcase
        // A redirect kills any response this cycle; DROP only while one is still owed.
        if (redirect_valid) begin
            push = 1'b0;
            if ((state == FETCH && transfer) || (state != FETCH && !imem_rsp_valid))
                stateNext = DROP;
            else
                stateNext = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            fetchPc <= RESET_PC;
        end else begin
            state <= stateNext;
            if (redirect_valid) fetchPc <= redirect_pc & 32'hFFFF_FFFC;
            else if (transfer)  fetchPc <= fetchPc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) reqPc <= fetchPc;
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) uBuffer (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .pushPc   (reqPc),
        .pushInst (imem_rsp_data),
        .pop      (pop),
        .count    (count),
        .headPc   (inst_pc),
        .headInst (inst_data)
    );

    assign inst_valid     = (count != '0);
    assign inst_opcode    = inst_data[6:0];
    assign misalign_fault = fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [6:0]  inst_opcode;
    logic        inst_ready = 1'b0;
    logic        misalign_fault;

    int vectors = 0;
    int miscompares = 0;

    // Memory responder state
    logic        memBusy = 1'b0;
    logic [31:0] memAddr = 32'h0;
    int          memWait = 0;
    int          memLat = 1;
    logic        memLatRand = 1'b0;
    int          memViolation = 0;

    // Snapshot of DUT outputs taken just before each active edge
    logic        sReqValid, sXfer, sRsp, sInstValid, sPop, sFault;
    logic [31:0] sReqAddr, sInstPc, sInstData;
    logic [6:0]  sOpcode;

    instr_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .inst_ready     (inst_ready),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [6:0] opc;
        if (a == 32'h0) return 32'hDEAD_BEEF;
        if (a == 32'h8) return 32'h00A0_0093;
        case (a[5:4])
            2'd0:    opc = 7'b0110011;
            2'd1:    opc = 7'b0010011;
            2'd2:    opc = 7'b0000011;
            default: opc = 7'b0100011;
        endcase
        return {a[26:2] ^ 25'h0ACE5A1, opc};
    endfunction

    task automatic doReset();
        reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        memBusy = 1'b0;
        memWait = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, snapshot, clock, update memory.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic iRdy, input logic rdy);
        redirect_valid = redir;
        redirect_pc = rpc;
        inst_ready = iRdy;
        imem_req_ready = rdy;
        imem_rsp_valid = memBusy && (memWait == 0);
        imem_rsp_data = imem_rsp_valid ? memWord(memAddr) : 32'h0;
        #1;
        sReqValid = imem_req_valid;
        sReqAddr = imem_req_addr;
        sXfer = imem_req_valid && rdy;
        sRsp = imem_rsp_valid;
        sInstValid = inst_valid;
        sInstPc = inst_pc;
        sInstData = inst_data;
        sOpcode = inst_opcode;
        sPop = inst_valid && iRdy;
        sFault = misalign_fault;
        @(posedge clk);
        if (sXfer && memBusy && !sRsp) memViolation++;
        if (sRsp) memBusy = 1'b0;
        else if (memBusy) memWait--;
        if (sXfer) begin
            memBusy = 1'b1;
            memAddr = sReqAddr;
            memWait = memLatRand ? int'($urandom_range(0, 2)) : memLat - 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        doReset();
        memLatRand = 1'b0;
        memLat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (sInstValid !== 1'b1) begin
            miscompares++;
            $display("FAIL prereset_inst_valid got=%b want=1", sInstValid);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || misalign_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got inst_valid=%b req_valid=%b fault=%b want 0/0/0",
                     inst_valid, imem_req_valid, misalign_fault);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held_req_valid got=%b want=0", imem_req_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        memBusy = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            miscompares++;
            $display("FAIL release_first_req got valid=%b addr=%h want 1/%h",
                     imem_req_valid, imem_req_addr, RPC);
        end
    endtask

    task automatic test_sequential_fetch();
        logic [31:0] reqAddrs[$];
        logic [31:0] popPcs[$];
        logic [31:0] popData[$];
        logic [6:0]  popOps[$];
        logic        ivAt1, ivAt2;
        doReset();
        memLatRand = 1'b0;
        memLat = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (i == 1) ivAt1 = sInstValid;
            if (i == 2) ivAt2 = sInstValid;
            if (sXfer) reqAddrs.push_back(sReqAddr);
            if (sPop) begin
                popPcs.push_back(sInstPc);
                popData.push_back(sInstData);
                popOps.push_back(sOpcode);
            end
        end
        vectors++;
        if (ivAt1 !== 1'b0 || ivAt2 !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_to_valid_latency got c1=%b c2=%b want 0/1", ivAt1, ivAt2);
        end
        vectors++;
        if (reqAddrs.size() < 3 || reqAddrs[0] !== 32'h0 || reqAddrs[1] !== 32'h4 || reqAddrs[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL seq_req_addrs got n=%0d want 0,4,8", reqAddrs.size());
        end
        vectors++;
        if (popPcs.size() < 3 || popPcs[0] !== 32'h0 || popPcs[1] !== 32'h4 || popPcs[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL seq_inst_pcs got n=%0d want 0,4,8", popPcs.size());
        end else begin
            vectors++;
            if (popData[2] !== 32'h00A0_0093 || popOps[2] !== 7'b0010011) begin
                miscompares++;
                $display("FAIL seq_opcode got data=%h op=%b want 00a00093/0010011", popData[2], popOps[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          xfers = 0;
        int          lateReq = 0;
        logic [31:0] popPcs[$];
        doReset();
        memLatRand = 1'b0;
        memLat = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (sXfer) xfers++;
            if (i >= 4 && sReqValid) lateReq++;
        end
        vectors++;
        if (xfers != 2 || lateReq != 0) begin
            miscompares++;
            $display("FAIL full_stall got xfers=%0d late_req=%0d want 2/0", xfers, lateReq);
        end
        xfers = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (sXfer) xfers++;
            if (sPop) popPcs.push_back(sInstPc);
        end
        vectors++;
        if (popPcs.size() < 3 || popPcs[0] !== 32'h0 || popPcs[1] !== 32'h4 || popPcs[2] !== 32'h8 || xfers == 0) begin
            miscompares++;
            $display("FAIL drain_order got pops=%0d xfers=%0d want 0,4,8 and resume", popPcs.size(), xfers);
        end
    endtask

    task automatic test_redirect_wait();
        logic        gotReq = 1'b0, gotValid = 1'b0;
        logic [31:0] firstReq = 32'hX, validPc = 32'hX, validData = 32'hX;
        int          reqWhileBusy = 0;
        doReset();
        memLatRand = 1'b0;
        memLat = 3;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        if (sReqValid) reqWhileBusy++;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        if (sReqValid) reqWhileBusy++;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        if (sReqValid) reqWhileBusy++;
        vectors++;
        if (reqWhileBusy != 0) begin
            miscompares++;
            $display("FAIL drop_no_request got reqs=%0d want 0", reqWhileBusy);
        end
        for (int i = 0; i < 25 && !gotValid; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (sXfer && !gotReq) begin
                gotReq = 1'b1;
                firstReq = sReqAddr;
            end
            if (sInstValid) begin
                gotValid = 1'b1;
                validPc = sInstPc;
                validData = sInstData;
            end
        end
        vectors++;
        if (!gotReq || firstReq !== 32'h100) begin
            miscompares++;
            $display("FAIL redirect_wait_req got=%h want=00000100", firstReq);
        end
        vectors++;
        if (!gotValid || validPc !== 32'h100 || validData !== memWord(32'h100)) begin
            miscompares++;
            $display("FAIL redirect_wait_first_inst got pc=%h data=%h want 00000100/%h",
                     validPc, validData, memWord(32'h100));
        end
    endtask

    task automatic test_redirect_with_rsp();
        doReset();
        memLatRand = 1'b0;
        memLat = 1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (sReqValid !== 1'b1 || sReqAddr !== 32'h200 || sInstValid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_rsp got valid=%b addr=%h iv=%b want 1/00000200/0",
                     sReqValid, sReqAddr, sInstValid);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (sInstValid !== 1'b1 || sInstPc !== 32'h200) begin
            miscompares++;
            $display("FAIL redirect_rsp_inst got iv=%b pc=%h want 1/00000200", sInstValid, sInstPc);
        end
    endtask

    task automatic test_wrap();
        doReset();
        memLatRand = 1'b0;
        memLat = 1;
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (sXfer !== 1'b1 || sReqAddr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_top_req got xfer=%b addr=%h want 1/fffffffc", sXfer, sReqAddr);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (sReqAddr !== 32'h0 || sInstPc !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_next got addr=%h head=%h want 00000000/fffffffc", sReqAddr, sInstPc);
        end
    endtask

    task automatic test_misalign();
        int reqs = 0;
        doReset();
        memLatRand = 1'b0;
        memLat = 1;
        step(1'b1, 32'h102, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        `ifdef IFU_MISALIGN_CHECK_EN
        vectors++;
        if (sFault !== 1'b1 || sReqValid !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_fault got fault=%b req=%b want 1/0", sFault, sReqValid);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (sReqValid) reqs++;
        end
        vectors++;
        if (reqs != 0 || sFault !== 1'b1) begin
            miscompares++;
            $display("FAIL misalign_halt got reqs=%0d fault=%b want 0/1", reqs, sFault);
        end
        `else
        vectors++;
        if (sFault !== 1'b0 || sReqValid !== 1'b1 || sReqAddr !== 32'h100) begin
            miscompares++;
            $display("FAIL misalign_masked got fault=%b req=%b addr=%h want 0/1/00000100",
                     sFault, sReqValid, sReqAddr);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (sReqValid) reqs++;
        end
        vectors++;
        if (reqs == 0 || sFault !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_continue got reqs=%0d fault=%b want >0/0", reqs, sFault);
        end
        `endif
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] mPc, mReqPc, rpc, expData;
        logic        mOut, mLive, redir, iRdy, rdy, expRV;
        int          errBefore;
        doReset();
        memLatRand = 1'b1;
        memViolation = 0;
        mPc = RPC;
        mReqPc = 32'h0;
        mOut = 1'b0;
        mLive = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
            else                           rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            `ifndef IFU_MISALIGN_CHECK_EN
            rpc[1:0] = 2'($urandom_range(0, 3));
            `endif
            iRdy = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(redir, rpc, iRdy, rdy);
            errBefore = miscompares;
            expRV = !mOut && (q.size() < DEPTH);
            vectors++;
            if (sReqValid !== expRV) begin
                miscompares++;
                $display("FAIL rnd_req_valid cyc=%0d got=%b want=%b", cyc, sReqValid, expRV);
            end
            if (expRV) begin
                vectors++;
                if (sReqAddr !== mPc) begin
                    miscompares++;
                    $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", cyc, sReqAddr, mPc);
                end
            end
            vectors++;
            if (sInstValid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL rnd_inst_valid cyc=%0d got=%b want=%b", cyc, sInstValid, q.size() != 0);
            end
            if (q.size() != 0) begin
                expData = memWord(q[0]);
                vectors++;
                if (sInstPc !== q[0] || sInstData !== expData || sOpcode !== expData[6:0]) begin
                    miscompares++;
                    $display("FAIL rnd_head cyc=%0d got pc=%h data=%h op=%b want %h/%h/%b",
                             cyc, sInstPc, sInstData, sOpcode, q[0], expData, expData[6:0]);
                end
            end
            vectors++;
            if (sFault !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_fault cyc=%0d got=%b want=0", cyc, sFault);
            end
            if (miscompares != errBefore) break;
            // Reference update for the edge just taken
            if (redir) begin
                q.delete();
            end else begin
                if (sRsp && mLive) q.push_back(mReqPc);
                if (q.size() != 0 && sInstValid && iRdy) void'(q.pop_front());
            end
            if (sRsp) mOut = 1'b0;
            if (redir) mLive = 1'b0;
            if (expRV && rdy) begin
                mOut = 1'b1;
                mReqPc = mPc;
                mLive = !redir;
                mPc = mPc + 32'd4;
            end
            if (redir) mPc = rpc & 32'hFFFF_FFFC;
        end
        vectors++;
        if (memViolation != 0) begin
            miscompares++;
            $display("FAIL outstanding_limit got=%0d want=0", memViolation);
        end
        memLatRand = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=stuck want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_with_rsp();
        test_wrap();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
